nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder consuming the 4-bit carry-lookahead generator output (Cout[3:0], P[3:0]).

---
 rtl/coa_adder_pkg.sv | 24 ++
 rtl/cla4_carry_unit.sv | 27 ++
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/coa_adder_pkg.sv
// Shared definitions for the nibble-serial adder slice.
//   NIB_W   : bits processed per clock by the serial adder
//   state_t : controller states (3 is unused and treated as IDLE)
//   clog2   : index-width helper (never returns less than 1)
package coa_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla4_carry_unit.sv
// Combinational 4-bit carry-lookahead generator.
//   a, b : nibble operands
//   c    : carry into bit 0
//   p    : propagate terms (a ^ b)
//   cout : carry out of each bit position, flattened to two levels
module cla4_carry_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] cout,
  output logic [3:0] p
);

  logic [3:0] g;

  always_comb begin
    g = a & b;
    p = a ^ b;
    cout[0] = g[0] | (p[0] & c);
    cout[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cout[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c);
    cout[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c);
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LSB nibble first,
// carry chained between cycles through a register. start/busy/done handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request an add (honoured in IDLE or DONE only)
//   a, b, cin  : operands, captured on the accept cycle
//   busy       : high while nibbles are being processed
//   done       : one-cycle pulse, result valid
//   sum, cout  : a+b+cin modulo 2^WIDTH and carry out of the MSB
//   overflow   : signed overflow of the completed add
module nibble_serial_adder
  import coa_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / NIB_W;
  localparam int unsigned IDX_W = clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state, state_nx;
  logic             accept;
  logic [WIDTH-1:0] a_r, b_r, work, work_nx;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [3:0]       nib_a, nib_b, cu_cout, cu_p, nib_sum;

  cla4_carry_unit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .c    (carry),
    .cout (cu_cout),
    .p    (cu_p)
  );

  always_comb begin
    nib_a   = a_r[idx*NIB_W +: NIB_W];
    nib_b   = b_r[idx*NIB_W +: NIB_W];
    nib_sum = cu_p ^ {cu_cout[2:0], carry};
    // Final result register is loaded from work_nx so the last nibble lands
    // in the same edge that enters DONE.
    work_nx = work;
    work_nx[idx*NIB_W +: NIB_W] = nib_sum;
  end

  // IDLE, DONE and the unused encoding all share the accept behaviour.
  always_comb begin
    state_nx = ST_IDLE;
    accept   = 1'b0;
    case (state)
      ST_RUN:  state_nx = (idx == LAST) ? ST_DONE : ST_RUN;
      default: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end
      end
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      work     <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        carry <= cin;
        idx   <= '0;
      end else if (state == ST_RUN) begin
        carry <= cu_cout[3];
        idx   <= idx + 1'b1;
        work  <= work_nx;
        if (idx == LAST) begin
          sum      <= work_nx;
          cout     <= cu_cout[3];
          overflow <= cu_cout[2] ^ cu_cout[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, overflow;
  logic [15:0] sum;

  res_t expq[$];
  res_t hold = '0;
  res_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic rst_prev = 1'b1;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always @(posedge clk) rst_prev <= rst_n;

  function automatic res_t mk(input logic [15:0] s, input logic c, input logic v);
    res_t r;
    r.s = s;
    r.c = c;
    r.v = v;
    return r;
  endfunction

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] t;
    res_t r;
    t = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    r.s = t[15:0];
    r.c = t[16];
    r.v = (x[15] == y[15]) && (t[15] != x[15]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: results popped on done, outputs must hold otherwise.
  always @(negedge clk) begin
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    if (!rst_prev) begin
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", {14'd0, sum, cout, overflow}, 32'd0);
      hold = '0;
    end else if (done) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending add at %0t", $time);
      end else begin
        mon_e = expq.pop_front();
        check("result", {14'd0, sum, cout, overflow}, {14'd0, mon_e});
        hold = mon_e;
      end
    end else begin
      check("result_hold", {14'd0, sum, cout, overflow}, {14'd0, hold});
    end
  end

  // Called and returning at a negedge; leaves start low after the accept edge.
  task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                       input bit push, input res_t e);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: got busy=1 expected busy=0 within 50 cycles");
    end
    start = 1'b1;
    a = xa;
    b = xb;
    cin = xc;
    @(posedge clk);
    if (push) expq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    check("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    logic        rc;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: carry across a nibble boundary, with latency
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1, mk(16'h0100, 1'b0, 1'b0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("latency_busy", {31'd0, busy}, 32'd1);
      check("latency_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    check("latency_done", {31'd0, done}, 32'd1);

    // 2: full ripple
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    // 3: signed overflow cases
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b1, mk(16'h8000, 1'b0, 1'b1));
    issue(16'h8000, 16'h8000, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b1));

    // 4: start during RUN ignored, then back-to-back from DONE
    issue(16'h1234, 16'h4321, 1'b0, 1'b1, mk(16'h5555, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_in_done", {31'd0, done}, 32'd1);
    issue(16'h0001, 16'h0001, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b0));

    // 5: reset in the second RUN cycle aborts the add
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 6: random adds with random gaps
    for (int i = 0; i < 500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, 1'b1, model(ra, rb, rc));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", expq.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
